div_mant_core: RTL and testbench

Iterative restoring mantissa divider for the FP divide path. It sits directly upstream of the divider normaliser and produces the un-normalised quotient mantissa and biased exponent that the normaliser consumes. The normaliser then left-shifts the quotient and decrements the exponent. The block produces one quotient bit per clock and uses a start/busy/done handshake.

---
 rtl/div_mant_core.sv | 116 +++++++++++
 tb/tb_div_mant_core.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/div_mant_core.sv
// Restoring mantissa divider: one quotient bit per clock behind a start/busy/done handshake.
// Produces the un-normalised quotient, biased exponent, sticky and divide-by-zero flags.
module div_mant_core #(
    parameter int EXP_WIDTH  = 11,
    parameter int MANT_WIDTH = 52,
    parameter int BIAS       = 1023
) (
    input  logic                  in_Clk,
    input  logic                  in_Rst_N,
    input  logic                  in_Start,
    input  logic [EXP_WIDTH-1:0]  in_ExpA,
    input  logic [EXP_WIDTH-1:0]  in_ExpB,
    input  logic [MANT_WIDTH:0]   in_MantA,
    input  logic [MANT_WIDTH:0]   in_MantB,
    output logic [EXP_WIDTH-1:0]  out_Exp,
    output logic [MANT_WIDTH:0]   out_Mant,
    output logic                  out_Sticky,
    output logic                  out_DivZero,
    output logic                  out_Busy,
    output logic                  out_Done
);

    localparam int CNT_W = $clog2(MANT_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state_reg, state_next;
    logic [MANT_WIDTH+1:0]  rem_reg;
    logic [MANT_WIDTH:0]    divisor_reg;
    logic [MANT_WIDTH:0]    mant_reg;
    logic [EXP_WIDTH-1:0]   exp_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   sticky_reg;
    logic                   divzero_reg;

    logic                   accept;
    logic                   rem_ge;
    logic [MANT_WIDTH+1:0]  divisor_ext;
    logic [MANT_WIDTH+1:0]  rem_diff;
    logic [MANT_WIDTH+1:0]  rem_step;

    // One restoring step; the partial remainder stays below 2*divisor so the shift never overflows.
    always_comb begin
        divisor_ext = {1'b0, divisor_reg};
        rem_ge      = (rem_reg >= divisor_ext);
        rem_diff    = rem_ge ? (rem_reg - divisor_ext) : rem_reg;
        rem_step    = rem_diff << 1;
    end

    always_ff @(posedge in_Clk) begin
        if (!in_Rst_N) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        out_Busy   = (state_reg != IDLE);
        out_Done   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (in_Start) begin
                    accept     = 1'b1;
                    state_next = (in_MantB == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt_reg == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_Done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge in_Clk) begin
        if (!in_Rst_N) begin
            rem_reg     <= '0;
            divisor_reg <= '0;
            mant_reg    <= '0;
            exp_reg     <= '0;
            cnt_reg     <= '0;
            sticky_reg  <= 1'b0;
            divzero_reg <= 1'b0;
        end else if (accept) begin
            rem_reg     <= {1'b0, in_MantA};
            divisor_reg <= in_MantB;
            mant_reg    <= '0;
            exp_reg     <= in_ExpA - in_ExpB + EXP_WIDTH'(BIAS);
            cnt_reg     <= CNT_W'(MANT_WIDTH);
            sticky_reg  <= 1'b0;
            divzero_reg <= (in_MantB == '0);
        end else if (state_reg == RUN) begin
            // Quotient bits arrive MSB first, so shifting in lands bit cnt in place.
            rem_reg  <= rem_step;
            mant_reg <= {mant_reg[MANT_WIDTH-1:0], rem_ge};
            cnt_reg  <= cnt_reg - 1'b1;
            if (cnt_reg == '0) begin
                sticky_reg <= (rem_step != '0);
            end
        end
    end

    assign out_Exp     = exp_reg;
    assign out_Mant    = mant_reg;
    assign out_Sticky  = sticky_reg;
    assign out_DivZero = divzero_reg;

endmodule

// File: tb/tb_div_mant_core.sv
// Directed bench for div_mant_core: expected results queued at start, checked when out_Done pulses.
module tb_div_mant_core;

    localparam int EW = 11;
    localparam int MW = 52;

    logic          in_Clk = 1'b0;
    logic          in_Rst_N;
    logic          in_Start;
    logic [EW-1:0] in_ExpA, in_ExpB;
    logic [MW:0]   in_MantA, in_MantB;
    logic [EW-1:0] out_Exp;
    logic [MW:0]   out_Mant;
    logic          out_Sticky, out_DivZero, out_Busy, out_Done;

    typedef struct {
        logic [EW-1:0] e;
        logic [MW:0]   m;
        logic          s;
        logic          z;
    } res_t;

    res_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   done_count = 0;

    div_mant_core dut (
        .in_Clk     (in_Clk),
        .in_Rst_N   (in_Rst_N),
        .in_Start   (in_Start),
        .in_ExpA    (in_ExpA),
        .in_ExpB    (in_ExpB),
        .in_MantA   (in_MantA),
        .in_MantB   (in_MantB),
        .out_Exp    (out_Exp),
        .out_Mant   (out_Mant),
        .out_Sticky (out_Sticky),
        .out_DivZero(out_DivZero),
        .out_Busy   (out_Busy),
        .out_Done   (out_Done)
    );

    always #5 in_Clk = ~in_Clk;

    always @(posedge in_Clk) begin
        if (out_Done === 1'b1) done_count++;
    end

    function automatic res_t model(input logic [EW-1:0] ea, input logic [EW-1:0] eb,
                                   input logic [MW:0] ma, input logic [MW:0] mb);
        res_t          r;
        logic [2*MW:0] num;
        r.e = ea - eb + EW'(1023);
        if (mb == '0) begin
            r.m = '0;
            r.s = 1'b0;
            r.z = 1'b1;
        end else begin
            num = {ma, {MW{1'b0}}};
            r.m = (MW+1)'(num / mb);
            r.s = ((num % mb) != '0);
            r.z = 1'b0;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic start_op(input logic [EW-1:0] ea, input logic [EW-1:0] eb,
                            input logic [MW:0] ma, input logic [MW:0] mb);
        in_ExpA  = ea;
        in_ExpB  = eb;
        in_MantA = ma;
        in_MantB = mb;
        in_Start = 1'b1;
        sb.push_back(model(ea, eb, ma, mb));
        @(negedge in_Clk);
        in_Start = 1'b0;
        chk("busy_after_accept", {63'd0, out_Busy}, 64'd1);
    endtask

    task automatic wait_done(input string tag, input int lat, input int c0);
        int   cycles;
        res_t e;
        cycles = c0;
        while (out_Done !== 1'b1 && cycles < 200) begin
            @(negedge in_Clk);
            cycles++;
        end
        chk({tag, "_latency"}, 64'(cycles), 64'(lat));
        chk({tag, "_sb_nonempty"}, {63'd0, sb.size() > 0}, 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_mant"}, 64'(out_Mant), 64'(e.m));
            chk({tag, "_exp"}, 64'(out_Exp), 64'(e.e));
            chk({tag, "_sticky"}, {63'd0, out_Sticky}, {63'd0, e.s});
            chk({tag, "_divzero"}, {63'd0, out_DivZero}, {63'd0, e.z});
        end
        chk({tag, "_busy_at_done"}, {63'd0, out_Busy}, 64'd1);
        @(negedge in_Clk);
        chk({tag, "_done_cleared"}, {63'd0, out_Done}, 64'd0);
        chk({tag, "_busy_cleared"}, {63'd0, out_Busy}, 64'd0);
        $display("txn %s: cycles=%0d mant=%h exp=%h sticky=%0b divzero=%0b",
                 tag, cycles, out_Mant, out_Exp, out_Sticky, out_DivZero);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mant"}, 64'(out_Mant), 64'd0);
        chk({tag, "_exp"}, 64'(out_Exp), 64'd0);
        chk({tag, "_sticky"}, {63'd0, out_Sticky}, 64'd0);
        chk({tag, "_divzero"}, {63'd0, out_DivZero}, 64'd0);
        chk({tag, "_busy"}, {63'd0, out_Busy}, 64'd0);
        chk({tag, "_done"}, {63'd0, out_Done}, 64'd0);
    endtask

    localparam logic [MW:0] ONE     = 53'h10000000000000;
    localparam logic [MW:0] ONEHALF = 53'h18000000000000;

    initial begin
        int          d0;
        logic [MW:0] ma, mb;

        // Reset with start asserted: nothing may launch
        in_Rst_N = 1'b0;
        in_Start = 1'b1;
        in_ExpA  = 11'h400;
        in_ExpB  = 11'h3FF;
        in_MantA = ONEHALF;
        in_MantB = ONE;
        repeat (3) @(negedge in_Clk);
        chk_all_zero("reset");
        in_Start = 1'b0;
        in_Rst_N = 1'b1;
        @(negedge in_Clk);
        chk("idle_after_reset_busy", {63'd0, out_Busy}, 64'd0);

        start_op(11'h3FF, 11'h3FF, ONE, ONE);
        wait_done("one_div_one", MW + 2, 1);
        chk("one_div_one_mant_const", 64'(out_Mant), 64'h10000000000000);

        start_op(11'h3FF, 11'h3FF, ONE, ONEHALF);
        wait_done("one_div_onehalf", MW + 2, 1);
        chk("one_div_onehalf_mant_const", 64'(out_Mant), 64'h0AAAAAAAAAAAAA);
        chk("one_div_onehalf_sticky_const", {63'd0, out_Sticky}, 64'd1);

        start_op(11'h400, 11'h3FF, ONEHALF, ONE);
        wait_done("onehalf_div_one", MW + 2, 1);
        chk("onehalf_div_one_exp_const", 64'(out_Exp), 64'h400);

        start_op(11'h123, 11'h055, ONEHALF, '0);
        wait_done("div_zero", 1, 1);
        chk("div_zero_mant_const", 64'(out_Mant), 64'd0);

        // Largest-over-smallest mantissa and exponent wrap-around
        start_op(11'h000, 11'h7FF, {MW+1{1'b1}}, ONE);
        wait_done("max_over_min", MW + 2, 1);
        start_op(11'h7FF, 11'h000, ONE, {MW+1{1'b1}});
        wait_done("min_over_max", MW + 2, 1);

        for (int i = 0; i < 3; i++) begin
            ma = {1'b1, 20'($urandom), 32'($urandom)};
            mb = {1'b1, 20'($urandom), 32'($urandom)};
            start_op(11'($urandom), 11'($urandom), ma, mb);
            wait_done($sformatf("random%0d", i), MW + 2, 1);
        end

        // Start held high: operands changed after acceptance must not affect the first result
        d0       = done_count;
        in_ExpA  = 11'h3FF;
        in_ExpB  = 11'h3FF;
        in_MantA = ONE;
        in_MantB = ONEHALF;
        in_Start = 1'b1;
        sb.push_back(model(11'h3FF, 11'h3FF, ONE, ONEHALF));
        @(negedge in_Clk);
        in_ExpA  = 11'h401;
        in_ExpB  = 11'h3FE;
        in_MantA = ONEHALF;
        in_MantB = 53'h1C000000000000;
        sb.push_back(model(11'h401, 11'h3FE, ONEHALF, 53'h1C000000000000));
        wait_done("held_first", MW + 2, 1);
        wait_done("held_second", MW + 2, 0);
        in_Start = 1'b0;
        repeat (60) @(negedge in_Clk);
        chk("held_done_count", 64'(done_count - d0), 64'd2);
        chk("held_idle_after", {63'd0, out_Busy}, 64'd0);

        // Reset pulse mid-operation when cnt has reached 20
        start_op(11'h3FF, 11'h3FE, ONEHALF, ONE);
        repeat (32) @(negedge in_Clk);
        chk("abort_busy_before", {63'd0, out_Busy}, 64'd1);
        d0       = done_count;
        in_Rst_N = 1'b0;
        @(negedge in_Clk);
        in_Rst_N = 1'b1;
        chk_all_zero("abort");
        void'(sb.pop_back());
        repeat (60) @(negedge in_Clk);
        chk("abort_no_done", 64'(done_count - d0), 64'd0);
        $display("txn abort: done pulses after reset=%0d", done_count - d0);

        start_op(11'h3FF, 11'h3FF, ONEHALF, ONEHALF);
        wait_done("after_abort", MW + 2, 1);

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
